btn_debounce: RTL

Front-end conditioning stage for the board push-buttons (BTN1..BTN4). It synchronises the raw pad inputs to the system clock and debounces each one. It then emits clean level, press-pulse, release-pulse and long-press-pulse signals per button. The LED toggle logic sits directly downstream and consumes the single-cycle PRESS pulses instead of clocking on raw button edges.

---
 rtl/btn_pkg.sv | 22 ++
 rtl/btn_debounce_ch.sv | 109 ++++++++++
 rtl/btn_debounce.sv | 40 ++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioning front end:
// default channel count, 12 MHz timing defaults, level states and counter sizing.
package btn_pkg;

  localparam int unsigned NUM_BTN_DEF         = 4;
  // 20 ms of stable input at 12 MHz before a new level is accepted
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 240000;
  // 1 s of continuous press at 12 MHz before LONG fires
  localparam int unsigned LONG_CYCLES_DEF     = 12000000;

  // Debounced level of one channel
  typedef enum logic {
    BTN_UP   = 1'b0,
    BTN_DOWN = 1'b1
  } btn_state_e;

  // Bits needed for a counter that can hold the value n
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchroniser, debounce counter that accepts a
// new level after DEBOUNCE_CYCLES stable clocks, registered press/release
// pulses, and a saturating hold counter producing a single long-press pulse.
// The input is already polarity-corrected (1 = pressed).
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic lvl_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int unsigned DB_W   = cnt_w(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = cnt_w(LONG_CYCLES);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic [1:0]        sync_q;
  logic              s;

  btn_state_e        state_q, state_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_done_q, long_done_d;

  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;

  logic              lvl;

  assign s   = sync_q[1];
  assign lvl = (state_q == BTN_DOWN);

  // Two-flop synchroniser for the asynchronous pad
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
    end
  end

  // Level state, counters and registered pulses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= BTN_UP;
      db_cnt_q    <= '0;
      hold_q      <= '0;
      long_done_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      hold_q      <= hold_d;
      long_done_q <= long_done_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
    end
  end

  // Debounce: count clocks the synchronised input disagrees with the level;
  // any agreement restarts the count, the DEBOUNCE_CYCLES-th disagreement flips it
  always_comb begin
    state_d   = state_q;
    db_cnt_d  = '0;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (s != lvl) begin
      if (db_cnt_q == DB_LAST) begin
        state_d   = s ? BTN_DOWN : BTN_UP;
        press_d   = s;
        release_d = ~s;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  // Hold timer: counts while pressed, saturates at LONG_CYCLES-1; the done
  // flag keeps the long pulse to one per press once the counter sits saturated
  always_comb begin
    hold_d      = '0;
    long_done_d = 1'b0;
    long_d      = 1'b0;
    if (lvl) begin
      hold_d      = (hold_q == HOLD_LAST) ? hold_q : hold_q + HOLD_W'(1);
      long_d      = (hold_q == HOLD_LAST) && !long_done_q;
      long_done_d = long_done_q | long_d;
    end
  end

  assign lvl_o     = lvl;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioning front end: applies pad polarity and runs one
// independent debounce/long-press channel per button.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned NUM_BTN         = NUM_BTN_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF,
  parameter int unsigned ACTIVE_LOW      = 0
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NUM_BTN-1:0] BTN_RAW,
  output logic [NUM_BTN-1:0] BTN_LVL,
  output logic [NUM_BTN-1:0] PRESS,
  output logic [NUM_BTN-1:0] RELEASE,
  output logic [NUM_BTN-1:0] LONG
);

  logic [NUM_BTN-1:0] btn_pressed;

  // Normalise so that 1 always means pressed, ahead of the synchronisers
  assign btn_pressed = (ACTIVE_LOW != 0) ? ~BTN_RAW : BTN_RAW;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_ch (
      .clk_i    (CLK),
      .rst_ni   (RST_N),
      .btn_i    (btn_pressed[g]),
      .lvl_o    (BTN_LVL[g]),
      .press_o  (PRESS[g]),
      .release_o(RELEASE[g]),
      .long_o   (LONG[g])
    );
  end

endmodule
